// File: rtl/vga_pixel_feeder_if.sv
// vga_pixel_feeder_if
//   CPU-side write bus of the VGA pixel feeder.
//   Signals:
//     wr_valid  CPU word strobe; one word is taken per high cycle while wr_ready is high
//     wr_data   16-bit pixel/command word
//     wr_ready  feeder can accept a word (buffer not full)
//   Modports: master = CPU side, slave = feeder side.
interface vga_pixel_feeder_if;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder
//   Buffers pixel/command words written by the CPU and replays them to the VGA image
//   block as add_input/rgb_code pulses, with add_input always dropping between pixels.
//   Mirrors the image block's write cursor in pix_index.
//   Word format: [15]=0 pixel {[14:12] repeat-1, [11:0] RGB444}; [15]=1 command, [0]=1 clear.
//   Optional feature macro: VGA_FEED_RLE_EN (when defined, [14:12] repeats a pixel 1..8 times;
//   when undefined, [14:12] is ignored and every pixel word emits one pulse).
// Ports
//   i_clk_50     system clock, rising edge
//   i_reset      synchronous active-high reset
//   wr_bus       CPU write bus (wr_valid / wr_data / wr_ready), slave side
//   o_overflow   sticky: a write was attempted while full and the word was dropped
//   o_add_input  pixel strobe to the image block
//   o_rgb_code   pixel colour, stable while o_add_input is high
//   o_vga_clear  clear pulse to the image block
//   o_pix_index  mirror of the image-block cursor, 0..NPIX-1
//   o_busy       buffer non-empty or a word still being replayed
module vga_pixel_feeder #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned HOLD       = 1,
    parameter int unsigned NPIX       = 1200
) (
    input  logic                     i_clk_50,
    input  logic                     i_reset,
    vga_pixel_feeder_if.slave        wr_bus,
    output logic                     o_overflow,
    output logic                     o_add_input,
    output logic [11:0]              o_rgb_code,
    output logic                     o_vga_clear,
    output logic [10:0]              o_pix_index,
    output logic                     o_busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {StIdle, StAssert, StGap, StClear} state_e;

    // ---------------- input buffer ----------------
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [15:0]   w_head;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot.
    assign w_full          = (r_count == CW'(FIFO_DEPTH));
    assign w_empty         = (r_count == '0);
    assign w_push          = wr_bus.wr_valid && !w_full;
    assign wr_bus.wr_ready = !w_full;
    assign w_head          = r_mem[r_rptr];

    always_ff @(posedge i_clk_50) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_bus.wr_data;
        end
    end

    always_ff @(posedge i_clk_50) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (wr_bus.wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- replay FSM ----------------
    state_e        r_state;
    state_e        w_state_d;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_d;
    logic          w_hold_last;
    logic          w_load_rgb;
    logic          w_pix_inc;
    logic          w_pix_clr;
    logic          r_add_input;
    logic          r_vga_clear;
    logic [11:0]   r_rgb_code;
    logic [10:0]   r_pix_index;
    logic          w_more;

`ifdef VGA_FEED_RLE_EN
    logic [2:0]    r_remain;
    logic [2:0]    w_remain_d;

    assign w_more = (r_remain != 3'd0);
`else
    logic [2:0]    w_unused_repeat;

    assign w_more          = 1'b0;
    assign w_unused_repeat = w_head[14:12];
`endif

    assign w_hold_last = (r_hold == HW'(HOLD - 1));

    always_comb begin
        w_state_d  = r_state;
        w_hold_d   = r_hold;
        w_pop      = 1'b0;
        w_load_rgb = 1'b0;
        w_pix_inc  = 1'b0;
        w_pix_clr  = 1'b0;
`ifdef VGA_FEED_RLE_EN
        w_remain_d = r_remain;
`endif
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_hold_d = '0;
                    if (w_head[15]) begin
                        // Commands other than clear are consumed silently.
                        if (w_head[0]) begin
                            w_state_d = StClear;
                        end
                    end else begin
                        w_state_d  = StAssert;
                        w_load_rgb = 1'b1;
`ifdef VGA_FEED_RLE_EN
                        w_remain_d = w_head[14:12];
`endif
                    end
                end
            end
            StAssert: begin
                if (w_hold_last) begin
                    w_hold_d  = '0;
                    w_state_d = StGap;
                end else begin
                    w_hold_d = r_hold + 1'b1;
                end
            end
            StGap: begin
                if (w_hold_last) begin
                    w_hold_d  = '0;
                    w_pix_inc = 1'b1;
                    if (w_more) begin
                        w_state_d = StAssert;
`ifdef VGA_FEED_RLE_EN
                        w_remain_d = r_remain - 3'd1;
`endif
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_hold_d = r_hold + 1'b1;
                end
            end
            StClear: begin
                if (w_hold_last) begin
                    w_hold_d  = '0;
                    w_pix_clr = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_hold_d = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk_50) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_hold      <= '0;
            r_add_input <= 1'b0;
            r_vga_clear <= 1'b0;
            r_rgb_code  <= '0;
            r_pix_index <= '0;
`ifdef VGA_FEED_RLE_EN
            r_remain    <= '0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_hold      <= w_hold_d;
            // Strobes are registered copies of the next state, so they are glitch-free and
            // can never be high together.
            r_add_input <= (w_state_d == StAssert);
            r_vga_clear <= (w_state_d == StClear);
            if (w_load_rgb) begin
                r_rgb_code <= w_head[11:0];
            end
            if (w_pix_clr) begin
                r_pix_index <= '0;
            end else if (w_pix_inc) begin
                r_pix_index <= (r_pix_index == 11'(NPIX - 1)) ? 11'd0 : r_pix_index + 11'd1;
            end
`ifdef VGA_FEED_RLE_EN
            r_remain    <= w_remain_d;
`endif
        end
    end

    assign o_overflow  = r_overflow;
    assign o_add_input = r_add_input;
    assign o_rgb_code  = r_rgb_code;
    assign o_vga_clear = r_vga_clear;
    assign o_pix_index = r_pix_index;
    assign o_busy      = !w_empty || (r_state != StIdle);

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// tb_vga_pixel_feeder
//   Self-checking bench for vga_pixel_feeder: a table of single words run to completion,
//   hand-written sequences for ordering, overflow, cursor wrap and reset mid-pulse, and a
//   pulse monitor that pops an expected-event queue filled when words are accepted.
module tb_vga_pixel_feeder;

    localparam int HOLD = 1;
    localparam int NPIX = 1200;
`ifdef VGA_FEED_RLE_EN
    localparam bit RLE = 1'b1;
`else
    localparam bit RLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        overflow;
    logic        add_input;
    logic [11:0] rgb_code;
    logic        vga_clear;
    logic [10:0] pix_index;
    logic        busy;

    always #10 clk = ~clk;

    vga_pixel_feeder_if bus ();

    vga_pixel_feeder #(
        .FIFO_DEPTH (16),
        .HOLD       (HOLD),
        .NPIX       (NPIX)
    ) dut (
        .i_clk_50    (clk),
        .i_reset     (rst),
        .wr_bus      (bus),
        .o_overflow  (overflow),
        .o_add_input (add_input),
        .o_rgb_code  (rgb_code),
        .o_vga_clear (vga_clear),
        .o_pix_index (pix_index),
        .o_busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        is_clr;
        logic [11:0] rgb;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        logic [15:0] data;
        logic [10:0] pix;
        logic [11:0] rgb;
    } vec_t;
    vec_t vecs[7];

    bit seen_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected pulse events for one accepted word.
    task automatic push_word(input logic [15:0] d);
        int reps;
        if (d[15]) begin
            if (d[0]) sb.push_back('{1'b1, 12'h000});
        end else begin
            reps = RLE ? int'(d[14:12]) + 1 : 1;
            for (int i = 0; i < reps; i++) sb.push_back('{1'b0, d[11:0]});
        end
    endtask

    task automatic write_word(input logic [15:0] d, output bit acc);
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        acc = bus.wr_ready;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        if (acc) push_word(d);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
    endtask

    // Pulse monitor: order/colour via the queue, widths, gaps and exclusivity.
    logic prev_add = 1'b0;
    logic prev_clr = 1'b0;
    int   hi_add = 0;
    int   hi_clr = 0;
    int   lo_add = HOLD;

    always @(negedge clk) begin
        ev_t ev;
        if (rst) begin
            prev_add = 1'b0;
            prev_clr = 1'b0;
            hi_add   = 0;
            hi_clr   = 0;
            lo_add   = HOLD;
        end else begin
            if (add_input || vga_clear) check("strobe_exclusive", add_input && vga_clear, 0);
            if (add_input && rgb_code == 12'hBAD) seen_bad = 1'b1;
            if (add_input && !prev_add) begin
                check("add_gap_ok", lo_add >= HOLD, 1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_pulse: got rgb 0x%0h, expected no pulse", rgb_code);
                end else begin
                    ev = sb.pop_front();
                    check("pulse_kind", ev.is_clr, 0);
                    check("pulse_rgb", rgb_code, ev.rgb);
                end
            end
            if (vga_clear && !prev_clr) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_clear: got vga_clear 1, expected no clear");
                end else begin
                    ev = sb.pop_front();
                    check("clear_kind", ev.is_clr, 1);
                end
            end
            if (!add_input && prev_add) check("add_width", hi_add, HOLD);
            if (!vga_clear && prev_clr) check("clr_width", hi_clr, HOLD);
            hi_add   = add_input ? hi_add + 1 : 0;
            hi_clr   = vga_clear ? hi_clr + 1 : 0;
            lo_add   = add_input ? 0 : lo_add + 1;
            prev_add = add_input;
            prev_clr = vga_clear;
        end
    end

    initial begin
        bit acc;
        int n;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 16'h0000;

        vecs[0] = '{16'h0F00, 11'd1,                   12'hF00};
        vecs[1] = '{16'h70A5, RLE ? 11'd9  : 11'd2,    12'h0A5};
        vecs[2] = '{16'h8000, RLE ? 11'd9  : 11'd2,    12'h0A5};
        vecs[3] = '{16'h1123, RLE ? 11'd11 : 11'd3,    12'h123};
        vecs[4] = '{16'h8001, 11'd0,                   12'h123};
        vecs[5] = '{16'h0FFF, 11'd1,                   12'hFFF};
        vecs[6] = '{16'h2456, RLE ? 11'd4  : 11'd2,    12'h456};

        // Reset state
        do_reset();
        check("rst_add_input", add_input, 0);
        check("rst_vga_clear", vga_clear, 0);
        check("rst_rgb_code", rgb_code, 0);
        check("rst_pix_index", pix_index, 0);
        check("rst_overflow", overflow, 0);
        check("rst_wr_ready", bus.wr_ready, 1);
        check("rst_busy", busy, 0);

        // Single words, each run to completion
        for (int i = 0; i < 7; i++) begin
            write_word(vecs[i].data, acc);
            check("vec_accepted", acc, 1);
            wait_idle("vec");
            check("vec_pix_index", pix_index, vecs[i].pix);
            check("vec_rgb_hold", rgb_code, vecs[i].rgb);
            check("vec_sb_drained", sb.size(), 0);
        end

        // Pixel, clear, pixel back-to-back: order kept, cursor cleared then advanced
        write_word(16'h0111, acc);
        write_word(16'h8001, acc);
        write_word(16'h0222, acc);
        wait_idle("order");
        check("order_pix_index", pix_index, 1);
        check("order_sb_drained", sb.size(), 0);

        // Fill until full, then one dropped write
        do_reset();
        n = 0;
        while (n < 64 && bus.wr_ready) begin
            write_word(16'(n), acc);
            n++;
        end
        check("fifo_full_ready", bus.wr_ready, 0);
        check("no_overflow_yet", overflow, 0);
        write_word(16'h0BAD, acc);
        check("full_write_dropped", acc, 0);
        check("overflow_set", overflow, 1);
        wait_idle("overflow");
        check("dropped_never_shown", seen_bad, 0);
        check("overflow_sticky", overflow, 1);
        check("overflow_sb_drained", sb.size(), 0);
        do_reset();
        check("overflow_cleared", overflow, 0);

        // Cursor wrap at NPIX
        for (int i = 0; i < NPIX - 1; i++) begin
            acc = 1'b0;
            while (!acc) write_word(16'(i & 12'hFFF), acc);
        end
        wait_idle("wrap_pre");
        check("pix_index_last", pix_index, NPIX - 1);
        write_word(16'h0ABC, acc);
        wait_idle("wrap");
        check("pix_index_wrapped", pix_index, 0);
        check("wrap_sb_drained", sb.size(), 0);

        // Reset while a pulse is high with words still queued
        for (int i = 0; i < 7; i++) write_word(16'h0300 + 16'(i), acc);
        n = 0;
        while (n < 20 && !add_input) begin
            @(negedge clk);
            n++;
        end
        check("midpulse_add_seen", add_input, 1);
        check("midpulse_busy_before", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check("midpulse_add_input", add_input, 0);
        check("midpulse_busy", busy, 0);
        check("midpulse_wr_ready", bus.wr_ready, 1);
        check("midpulse_pix_index", pix_index, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_quiet", busy, 0);
        check("post_reset_no_pulses", add_input, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
